// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet receive definitions: FSM states, framing constants,
// header layout and CRC-32 helpers.
package ethernet_header_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DISCARD
    } rx_state_t;

    localparam int PREAMBLE_SFD_BYTES = 8;
    localparam int HEADER_BYTES       = 14;
    localparam int FCS_BYTES          = 4;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } eth_header_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // Reflected CRC-32, LSB-first, one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] poly_r;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) begin
            poly_r[i] = CRC32_POLY[31-i];
        end
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_byte_fifo.sv
// Synchronous 9-bit FIFO (payload byte + last flag) with full/empty flags;
// writes while full are dropped.
module axis_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       rd_en,
    output logic [8:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/packet_recv.sv
// RMII receive front end: strips preamble/SFD, holds the MAC header, streams
// the payload without FCS. Optional FCS check under PACKET_RECV_FCS_CHECK_EN.
module packet_recv
    import ethernet_header_pkg::*;
#(
    parameter int PAYLOAD_FIFO_DEPTH  = 16,
    parameter int MIN_PREAMBLE_DIBITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  RXD,
    input  logic        RXDV,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        header_valid,
    input  logic        header_rd,
    output logic [47:0] dest_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype
`ifdef PACKET_RECV_FCS_CHECK_EN
    ,
    output logic        bad_frame
`endif
);

    // state       | meaning
    // ST_IDLE     | no carrier, waiting for the first preamble dibit
    // ST_PREAMBLE | counting 01 dibits, waiting for the 11 SFD dibit
    // ST_HEADER   | assembling the 14 header bytes
    // ST_PAYLOAD  | streaming payload through the FCS delay line
    // ST_DISCARD  | malformed preamble, ignore until carrier drops

    localparam logic [7:0] MIN_PRE  = 8'(MIN_PREAMBLE_DIBITS);
    localparam logic [3:0] HDR_LAST = 4'(HEADER_BYTES - 1);
    localparam logic [2:0] DL_FULL  = 3'(FCS_BYTES);

    rx_state_t   state;
    rx_state_t   state_nx;

    logic [5:0]  sh6;
    logic [7:0]  dibit_byte;
    logic [1:0]  dibit_cnt;
    logic [7:0]  pre_cnt;
    logic [3:0]  hdr_cnt;
    logic        byte_done;
    logic        sfd_seen;
    logic        frame_end;

    logic        byte_stb;
    logic        byte_hdr;
    logic        byte_hlast;
    logic [7:0]  byte_data;
    logic        eof_stb;

    logic [103:0] hdr_sr;
    eth_header_t  hdr_q;

    logic [31:0] dline;
    logic [2:0]  dl_cnt;
    logic        dl_full;
    logic [7:0]  pend;
    logic        pend_valid;

    logic        push_valid;
    logic [8:0]  push_word;
    logic [8:0]  fifo_word;
    logic        fifo_full;
    logic        fifo_empty;

    assign dibit_byte = {RXD, sh6};
    assign byte_done  = RXDV && (dibit_cnt == 2'd3) &&
                        ((state == ST_HEADER) || (state == ST_PAYLOAD));
    assign sfd_seen   = (state == ST_PREAMBLE) && (state_nx == ST_HEADER);
    assign frame_end  = (state == ST_PAYLOAD) && !RXDV;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (RXDV && (RXD == PREAMBLE_DIBIT)) state_nx = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (!RXDV)                                       state_nx = ST_IDLE;
                else if (RXD == PREAMBLE_DIBIT)                  state_nx = ST_PREAMBLE;
                else if ((RXD == SFD_DIBIT) && (pre_cnt >= MIN_PRE)) state_nx = ST_HEADER;
                else                                             state_nx = ST_DISCARD;
            end
            ST_HEADER: begin
                if (!RXDV)                                  state_nx = ST_IDLE;
                else if (byte_done && (hdr_cnt == HDR_LAST)) state_nx = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (!RXDV) state_nx = ST_IDLE;
            end
            ST_DISCARD: begin
                if (!RXDV) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Dibit/byte assembly; completed bytes are registered and acted on one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh6        <= '0;
            dibit_cnt  <= '0;
            pre_cnt    <= '0;
            hdr_cnt    <= '0;
            byte_stb   <= 1'b0;
            byte_hdr   <= 1'b0;
            byte_hlast <= 1'b0;
            byte_data  <= '0;
            eof_stb    <= 1'b0;
        end else begin
            byte_stb <= byte_done;
            eof_stb  <= frame_end;
            if (byte_done) begin
                byte_data  <= dibit_byte;
                byte_hdr   <= (state == ST_HEADER);
                byte_hlast <= (state == ST_HEADER) && (hdr_cnt == HDR_LAST);
            end
            if (RXDV && ((state == ST_HEADER) || (state == ST_PAYLOAD))) begin
                dibit_cnt <= dibit_cnt + 2'd1;
                sh6       <= dibit_byte[7:2];
            end else begin
                dibit_cnt <= '0;
            end
            if (state == ST_IDLE) begin
                pre_cnt <= 8'd1;
            end else if ((state == ST_PREAMBLE) && (RXD == PREAMBLE_DIBIT) && (pre_cnt != 8'hFF)) begin
                pre_cnt <= pre_cnt + 8'd1;
            end
            if (sfd_seen) begin
                hdr_cnt <= '0;
            end else if (byte_done && (state == ST_HEADER)) begin
                hdr_cnt <= hdr_cnt + 4'd1;
            end
        end
    end

    assign dl_full = (dl_cnt == DL_FULL);

    // The newest four bytes may be FCS, so a payload byte is released only
    // once four more bytes have arrived behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_sr       <= '0;
            hdr_q        <= '0;
            header_valid <= 1'b0;
            dline        <= '0;
            dl_cnt       <= '0;
            pend         <= '0;
            pend_valid   <= 1'b0;
        end else begin
            if (byte_stb && byte_hdr) hdr_sr <= {hdr_sr[95:0], byte_data};
            if (byte_stb && byte_hlast) begin
                hdr_q        <= {hdr_sr, byte_data};
                header_valid <= 1'b1;
            end else if (header_rd) begin
                header_valid <= 1'b0;
            end
            if (eof_stb) begin
                dline      <= '0;
                dl_cnt     <= '0;
                pend_valid <= 1'b0;
            end else if (byte_stb && !byte_hdr) begin
                dline <= {dline[23:0], byte_data};
                if (dl_full) begin
                    pend       <= dline[31:24];
                    pend_valid <= 1'b1;
                end else begin
                    dl_cnt <= dl_cnt + 3'd1;
                end
            end
        end
    end

    assign push_valid = pend_valid && (eof_stb || (byte_stb && !byte_hdr && dl_full));
    assign push_word  = {eof_stb, pend};

    axis_byte_fifo #(
        .DEPTH(PAYLOAD_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_valid),
        .wr_data (push_word),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? 8'd0 : fifo_word[7:0];
    assign m_axis_tlast  = !fifo_empty && fifo_word[8];

    assign dest_mac  = hdr_q.dest_mac;
    assign src_mac   = hdr_q.src_mac;
    assign ethertype = hdr_q.ethertype;

`ifdef PACKET_RECV_FCS_CHECK_EN
    logic [31:0] crc;
    logic [31:0] fcs_rx;

    // CRC covers header bytes and each payload byte as it leaves the delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC32_INIT;
        end else if (sfd_seen) begin
            crc <= CRC32_INIT;
        end else if (byte_stb && byte_hdr) begin
            crc <= crc32_byte(crc, byte_data);
        end else if (byte_stb && dl_full) begin
            crc <= crc32_byte(crc, dline[31:24]);
        end
    end

    assign fcs_rx    = {dline[7:0], dline[15:8], dline[23:16], dline[31:24]};
    assign bad_frame = eof_stb && pend_valid && ((~crc) != fcs_rx);
`endif

    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule

// File: tb/tb_packet_recv.sv
// Directed bench for packet_recv; FCS checks active when
// PACKET_RECV_FCS_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_packet_recv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  RXD = 2'b00;
    logic        RXDV = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        header_valid;
    logic        header_rd = 1'b0;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
`ifdef PACKET_RECV_FCS_CHECK_EN
    logic        bad_frame;
`endif

    packet_recv #(
        .PAYLOAD_FIFO_DEPTH (16),
        .MIN_PREAMBLE_DIBITS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RXD          (RXD),
        .RXDV         (RXDV),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .header_valid (header_valid),
        .header_rd    (header_rd),
        .dest_mac     (dest_mac),
        .src_mac      (src_mac),
        .ethertype    (ethertype)
`ifdef PACKET_RECV_FCS_CHECK_EN
        ,
        .bad_frame    (bad_frame)
`endif
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] rx_q[$];
    int   hv_rise_cyc = -1;
    logic hv_prev = 1'b0;
    int   bad_cnt = 0;
    int   bad_cyc = -1;
    int   last_cyc = -1;

    always @(negedge clk) begin
        #2;
        if (m_axis_tvalid && m_axis_tready) begin
            rx_q.push_back({m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast) last_cyc = cyc;
        end
        if (header_valid && !hv_prev) hv_rise_cyc = cyc;
        hv_prev = header_valid;
`ifdef PACKET_RECV_FCS_CHECK_EN
        if (bad_frame) begin
            bad_cnt++;
            bad_cyc = cyc;
        end
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] frm[$];
    int b13_cyc = -1;

    task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                         input int n, input logic [7:0] fill, input logic [7:0] lastb,
                         input logic [31:0] fcs);
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(s[i*8 +: 8]);
        frm.push_back(t[15:8]);
        frm.push_back(t[7:0]);
        for (int i = 0; i < n - 1; i++) frm.push_back(fill);
        frm.push_back(lastb);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[i*8 +: 8]);
    endtask

    task automatic dib(input logic v, input logic [1:0] d);
        @(negedge clk);
        RXDV = v;
        RXD  = d;
    endtask

    task automatic send(input int max_dibits, input logic bad_pre);
        logic [7:0] b;
        for (int i = 0; i < 31; i++) dib(1'b1, (bad_pre && i == 10) ? 2'b10 : 2'b01);
        dib(1'b1, 2'b11);
        for (int i = 0; i < frm.size() * 4 && i < max_dibits; i++) begin
            b = frm[i/4];
            dib(1'b1, b[(i%4)*2 +: 2]);
            if (i == 13*4 + 3) b13_cyc = cyc + 1;
        end
        repeat (12) dib(1'b0, 2'b00);
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        header_rd = 1'b1;
        @(negedge clk);
        header_rd = 1'b0;
        #2;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [7:0] fill,
                                input logic [7:0] lastb, input int exp_last_idx);
        int bad;
        int last_idx;
        int last_cnt;
        logic [7:0] e;
        bad = 0;
        last_idx = -1;
        last_cnt = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            e = (i == n - 1) ? lastb : fill;
            if (i >= n || rx_q[i][7:0] !== e) bad++;
            if (rx_q[i][8]) begin
                last_cnt++;
                last_idx = i;
            end
        end
        chk({tag, "_count"}, 64'(rx_q.size()), 64'(n));
        chk({tag, "_data"}, 64'(bad), 64'd0);
        chk({tag, "_tlast_pos"}, 64'(last_idx), 64'(exp_last_idx));
        chk({tag, "_tlast_cnt"}, 64'(last_cnt), (exp_last_idx >= 0) ? 64'd1 : 64'd0);
    endtask

    localparam logic [47:0] D1 = 48'h00183E04B3F2;
    localparam logic [47:0] S1 = 48'h54E1AD330D32;
    localparam logic [15:0] T1 = 16'h0040;
    localparam logic [31:0] F1 = 32'hDA874E20;
    localparam logic [47:0] D2 = 48'h112233445566;
    localparam logic [47:0] S2 = 48'hA0B0C0D0E0F0;
    localparam logic [15:0] T2 = 16'h0800;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_hv", 64'(header_valid), 64'd0);
        chk("rst_dest", 64'(dest_mac), 64'd0);
        chk("rst_src", 64'(src_mac), 64'd0);
        chk("rst_type", 64'(ethertype), 64'd0);
`ifdef PACKET_RECV_FCS_CHECK_EN
        chk("rst_bad", 64'(bad_frame), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // frame 1, streaming
        build(D1, S1, T1, 64, 8'hAA, 8'hFF, F1);
        rx_q.delete();
        send(100000, 1'b0);
        chk("f1_hv", 64'(header_valid), 64'd1);
        chk("f1_dest", 64'(dest_mac), 64'(D1));
        chk("f1_src", 64'(src_mac), 64'(S1));
        chk("f1_type", 64'(ethertype), 64'(T1));
        chk("f1_hv_latency", 64'(hv_rise_cyc - b13_cyc), 64'd1);
        check_stream("f1", 64, 8'hAA, 8'hFF, 63);
        chk("f1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

        // header_rd clears valid, fields hold
        pulse_rd();
        chk("rd_hv", 64'(header_valid), 64'd0);
        chk("rd_dest", 64'(dest_mac), 64'(D1));
        chk("rd_type", 64'(ethertype), 64'(T1));

        // backpressure: FIFO fills with the first 16 payload bytes
        m_axis_tready = 1'b0;
        rx_q.delete();
        send(100000, 1'b0);
        chk("bp_hv", 64'(header_valid), 64'd1);
        chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("bp_tdata", 64'(m_axis_tdata), 64'hAA);
        chk("bp_tlast", 64'(m_axis_tlast), 64'd0);
        pulse_rd();
        repeat (96) @(negedge clk);
        build(D2, S2, T2, 8, 8'h5A, 8'hC3, 32'h0);
        send(100000, 1'b0);
        chk("bp2_hv", 64'(header_valid), 64'd1);
        chk("bp2_dest", 64'(dest_mac), 64'(D2));
        chk("bp2_src", 64'(src_mac), 64'(S2));
        chk("bp2_type", 64'(ethertype), 64'(T2));
        chk("bp2_tdata_held", 64'(m_axis_tdata), 64'hAA);
        rx_q.delete();
        m_axis_tready = 1'b1;
        repeat (30) @(negedge clk);
        #2;
        check_stream("bp_drain", 16, 8'hAA, 8'hAA, -1);
        chk("bp_drain_tvalid", 64'(m_axis_tvalid), 64'd0);

        // truncated header: carrier drops after dibit 2 of byte 10
        pulse_rd();
        rx_q.delete();
        build(D1, S1, T1, 64, 8'hAA, 8'hFF, F1);
        send(42, 1'b0);
        chk("trunc_hv", 64'(header_valid), 64'd0);
        chk("trunc_dest", 64'(dest_mac), 64'(D2));
        chk("trunc_stream", 64'(rx_q.size()), 64'd0);
        send(100000, 1'b0);
        chk("trunc_next_hv", 64'(header_valid), 64'd1);
        chk("trunc_next_dest", 64'(dest_mac), 64'(D1));
        check_stream("trunc_next", 64, 8'hAA, 8'hFF, 63);

        // bad preamble dibit: whole burst discarded
        pulse_rd();
        rx_q.delete();
        build(D2, S2, T2, 8, 8'h5A, 8'hC3, 32'h0);
        send(100000, 1'b1);
        chk("badpre_hv", 64'(header_valid), 64'd0);
        chk("badpre_dest", 64'(dest_mac), 64'(D1));
        chk("badpre_stream", 64'(rx_q.size()), 64'd0);
        send(100000, 1'b0);
        chk("badpre_next_hv", 64'(header_valid), 64'd1);
        chk("badpre_next_src", 64'(src_mac), 64'(S2));
        check_stream("badpre_next", 8, 8'h5A, 8'hC3, 7);

`ifdef PACKET_RECV_FCS_CHECK_EN
        // FCS check: good frame, then the same frame with a zero FCS
        bad_cnt = 0;
        rx_q.delete();
        build(D1, S1, T1, 64, 8'hAA, 8'hFF, F1);
        send(100000, 1'b0);
        chk("fcs_good_bad_cnt", 64'(bad_cnt), 64'd0);
        rx_q.delete();
        build(D1, S1, T1, 64, 8'hAA, 8'hFF, 32'h0);
        send(100000, 1'b0);
        chk("fcs_bad_cnt", 64'(bad_cnt), 64'd1);
        chk("fcs_bad_vs_tlast", 64'(last_cyc - bad_cyc), 64'd1);
        check_stream("fcs_bad", 64, 8'hAA, 8'hFF, 63);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_recv.md
# packet_recv

RMII receive front end for the Ethernet datapath: samples the 2-bit RMII receive bus at 50 MHz and strips the preamble and SFD. Captures the 14-byte MAC header into a held, handshaken register set. Streams the payload bytes, with the FCS removed, onto a byte-wide AXI-Stream master. Sits between the PHY pins and the downstream protocol parsers.

## Interface
- `PAYLOAD_FIFO_DEPTH`, default 16: payload byte FIFO depth; power of two, at least 4.
- `MIN_PREAMBLE_DIBITS`, default 4: minimum count of consecutive `01` dibits required before the SFD.
- `clk` in 1: 50 MHz RMII reference clock; all inputs are sampled on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `RXD` in 2: RMII receive dibit; `RXD[0]` carries the earlier (less significant) bit.
- `RXDV` in 1: receive data valid / carrier.
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: payload byte valid.
- `m_axis_tlast` out 1: marks the final payload byte of a frame.
- `m_axis_tready` in 1: downstream accept.
- `header_valid` out 1: header fields are held and valid.
- `header_rd` in 1: consumer acknowledge; clears `header_valid`.
- `dest_mac` out 48: destination MAC; the first byte received is `[47:40]`.
- `src_mac` out 48: source MAC; same byte order as `dest_mac`.
- `ethertype` out 16: length/type field; the first byte received is `[15:8]`.
- `bad_frame` out 1: present only when `PACKET_RECV_FCS_CHECK_EN` is defined.

## Operation
- Byte assembly: `byte <= {RXD, byte[7:2]}`; a byte is complete after 4 dibits. Bytes are counted from the first byte after the SFD.
- FSM states and transitions:
  - IDLE: on `RXDV=1` with `RXD=01`, go to PREAMBLE.
  - PREAMBLE: counts `01` dibits. On `11` with count ≥ `MIN_PREAMBLE_DIBITS`, go to HEADER. Any other dibit goes to DISCARD.
  - HEADER: bytes 0–5 go to dest, bytes 6–11 to src, bytes 12–13 to ethertype. After byte 13, latch all three outputs, set `header_valid`, and go to PAYLOAD.
  - PAYLOAD: every byte enters a 4-byte delay line. The byte leaving the delay line is held in a pending register. The previous pending byte is pushed to the FIFO with `tlast=0`.
  - DISCARD: wait for `RXDV=0`, then go to IDLE.
- `RXDV` falling in any state returns to IDLE. A partial byte is discarded.
- `RXDV` falling in PAYLOAD: the 4 bytes in the delay line are the FCS. The pending byte, if any, is pushed with `tlast=1`.
- `RXDV` falling in HEADER: the header is not latched and no payload is emitted.
- Payload length is purely RXDV-delimited; the ethertype value is not interpreted.
- `header_valid` clears on any cycle in which `header_rd=1`.
- If a new header latches while `header_valid=1`, the fields are overwritten and `header_valid` stays 1. A simultaneous latch and `header_rd` leaves `header_valid=1`.
- FIFO full on push: the byte is discarded, including its `tlast`. The pending, held and streamed data is otherwise unaffected.

## Timing
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; delay line cleared.
- `header_valid` and the header fields update on the clock edge after the edge that samples the 4th dibit of byte 13.
- A FIFO push occurs on the edge after byte completion. `m_axis_tvalid` rises 1 cycle after a push into an empty FIFO.
- AXIS protocol: `tdata`/`tlast` are stable while `tvalid=1` and `tready=0`. A byte pops when `tvalid & tready`.
- FIFO write and read may occur in the same cycle.

## Configuration
- `PACKET_RECV_FCS_CHECK_EN` defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final inversion) runs over dest MAC through the last payload byte.
  - The computed value is compared against the 4 FCS bytes (first received byte is least significant).
  - `bad_frame` pulses for 1 cycle, coincident with the `tlast` push, on a mismatch.
- Macro undefined: no CRC logic, no `bad_frame` port.

## Structure
- Shared package `ethernet_header_pkg` holds:
  - the FSM state enum;
  - constants for the 8-byte preamble/SFD, 14-byte header, 4-byte FCS, and the preamble dibit `01` / SFD dibit `11`;
  - an `eth_header_t` packed struct {dest_mac, src_mac, ethertype};
  - the CRC-32 polynomial/init constants.
- One sub-module, `axis_byte_fifo`: 9-bit wide (data + last), synchronous, full/empty flags.

## Test plan
- Frame 1 (`tready=1`): dest 0x00183E04B3F2, src 0x54E1AD330D32, ethertype 0x0040, 63×0xAA then 0xFF, FCS 0xDA874E20.
  - Header fields and `header_valid=1` appear within 1 cycle of byte 13.
  - Exactly 64 bytes are streamed; `tlast` is on 0xFF only.
- `header_rd` pulse → `header_valid` is 0 on the next cycle; the fields are unchanged.
- `tready=0` for the whole of Frame 1 → 16 bytes (0xAA) are held; `tvalid` stays 1 and the rest are dropped.
  - A second frame 96 cycles later updates the header and sets `header_valid`.
- `RXDV` drops after dibit 2 of byte 10 → no header latch, no stream output; the next valid frame is received normally.
- Bad preamble (`RXD=10` mid-preamble) → DISCARD; no output until `RXDV` falls.
- With the macro defined: a correct-FCS frame gives `bad_frame=0`; the same frame with FCS 0x00000000 pulses `bad_frame` with `tlast`.
